// File: rtl/alu_issue.sv
// Issue stage for the RV32I integer ALU: decodes OP/OP-IMM into ALU fields and
// buffers them in a main+skid pair so in_ready comes straight from a flop.
module alu_issue #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs1_value,
    input  logic [DATA_WIDTH-1:0] rs2_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] lhs,
    output logic [DATA_WIDTH-1:0] rhs,
    output logic [2:0]            operation,
    output logic [6:0]            metadata,
    output logic [4:0]            rd,
    output logic                  illegal
);

    typedef struct packed {
        logic                  illegal;
        logic [DATA_WIDTH-1:0] lhs;
        logic [DATA_WIDTH-1:0] rhs;
        logic [2:0]            operation;
        logic [6:0]            metadata;
        logic [4:0]            rd;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] SHAMT_MASK = DATA_WIDTH'(DATA_WIDTH - 1);

    logic [6:0]            opcode_s;
    logic [2:0]            funct3_s;
    logic [6:0]            funct7_s;
    logic                  legal_s;
    logic [DATA_WIDTH-1:0] rhs_s;
    logic [6:0]            meta_s;
    entry_t                dec_s;
    logic                  in_xfer_s;
    logic                  out_xfer_s;
    logic                  unused_s;

    state_t state_r;
    entry_t main_r;
    entry_t skid_r;
    logic   in_ready_r;
    logic   out_valid_r;

    assign opcode_s   = instr[6:0];
    assign funct3_s   = instr[14:12];
    assign funct7_s   = instr[31:25];
    assign unused_s   = ^instr[19:15];
    assign in_xfer_s  = in_valid && in_ready_r;
    assign out_xfer_s = out_valid_r && out_ready;

    // Decode the presented instruction into an ALU entry; illegal ones carry zeroed fields.
    always_comb begin
        legal_s = 1'b0;
        rhs_s   = '0;
        meta_s  = 7'h00;
        dec_s   = '0;
        case (opcode_s)
            7'h33: begin
                legal_s = (funct7_s == 7'h00) ||
                          ((funct7_s == 7'h20) && ((funct3_s == 3'd0) || (funct3_s == 3'd5)));
                meta_s  = funct7_s;
                if ((funct3_s == 3'd1) || (funct3_s == 3'd5)) begin
                    rhs_s = rs2_value & SHAMT_MASK;
                end else begin
                    rhs_s = rs2_value;
                end
            end
            7'h13: begin
                case (funct3_s)
                    3'd1: begin
                        legal_s = (funct7_s == 7'h00);
                        meta_s  = 7'h00;
                        rhs_s   = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};
                    end
                    3'd5: begin
                        legal_s = (funct7_s == 7'h00) || (funct7_s == 7'h20);
                        meta_s  = funct7_s;
                        rhs_s   = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};
                    end
                    default: begin
                        legal_s = 1'b1;
                        meta_s  = 7'h00;
                        rhs_s   = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
                    end
                endcase
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
        if (legal_s) begin
            dec_s.illegal   = 1'b0;
            dec_s.lhs       = rs1_value;
            dec_s.rhs       = rhs_s;
            dec_s.operation = funct3_s;
            dec_s.metadata  = meta_s;
            dec_s.rd        = instr[11:7];
        end else begin
            dec_s         = '0;
            dec_s.illegal = 1'b1;
        end
    end

    // Main/skid occupancy FSM; in_ready and out_valid are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= EMPTY;
            main_r      <= '0;
            skid_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_xfer_s) begin
                        main_r      <= dec_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_r <= dec_s;
                    end else if (out_xfer_s) begin
                        out_valid_r <= 1'b0;
                        state_r     <= EMPTY;
                    end else if (in_xfer_s) begin
                        skid_r     <= dec_s;
                        in_ready_r <= 1'b0;
                        state_r    <= TWO;
                    end
                end
                TWO: begin
                    if (out_xfer_s) begin
                        main_r     <= skid_r;
                        in_ready_r <= 1'b1;
                        state_r    <= ONE;
                    end
                end
                default: begin
                    state_r     <= EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign lhs       = main_r.lhs;
    assign rhs       = main_r.rhs;
    assign operation = main_r.operation;
    assign metadata  = main_r.metadata;
    assign rd        = main_r.rd;
    assign illegal   = main_r.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus random traffic against a
// queue-based reference model of the decode rules and FIFO ordering.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [2:0]  operation;
    logic [6:0]  metadata;
    logic [4:0]  rd;
    logic        illegal;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        illegal;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [2:0]  op;
        logic [6:0]  meta;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];

    alu_issue #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .lhs(lhs), .rhs(rhs), .operation(operation), .metadata(metadata),
        .rd(rd), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode written directly from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit   ok;
        int   f3, f7, shamt;
        e     = '0;
        ok    = 0;
        f3    = int'(i[14:12]);
        f7    = int'(i[31:25]);
        shamt = int'(i[24:20]);
        if (i[6:0] == 7'h33) begin
            ok     = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            e.rhs  = (f3 == 1 || f3 == 5) ? (b % 32) : b;
            e.meta = f7[6:0];
        end else if (i[6:0] == 7'h13) begin
            if (f3 == 1) begin
                ok = (f7 == 0); e.rhs = shamt; e.meta = 7'h00;
            end else if (f3 == 5) begin
                ok = (f7 == 0 || f7 == 32); e.rhs = shamt; e.meta = f7[6:0];
            end else begin
                ok = 1; e.rhs = $signed(i) >>> 20; e.meta = 7'h00;
            end
        end
        if (ok) begin
            e.illegal = 1'b0;
            e.lhs     = a;
            e.op      = f3[2:0];
            e.rd      = i[11:7];
        end else begin
            e         = '0;
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    // One clock: drive at negedge, step the model at posedge, check at next negedge.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic ordy, output bit accepted);
        bit   in_x, out_x;
        exp_t e;
        in_valid  = iv;
        instr     = ins;
        rs1_value = a;
        rs2_value = b;
        out_ready = ordy;
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        in_x  = iv && (q.size() < 2);
        out_x = ordy && (q.size() > 0);
        e     = ref_decode(ins, a, b);
        @(posedge clk);
        if (out_x) void'(q.pop_front());
        if (in_x) q.push_back(e);
        accepted = in_x;
        @(negedge clk);
        check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            check("illegal",   {31'd0, illegal},   {31'd0, q[0].illegal});
            check("lhs",       lhs,                q[0].lhs);
            check("rhs",       rhs,                q[0].rhs);
            check("operation", {29'd0, operation}, {29'd0, q[0].op});
            check("metadata",  {25'd0, metadata},  {25'd0, q[0].meta});
            check("rd",        {27'd0, rd},        {27'd0, q[0].rd});
        end
    endtask

    initial begin
        bit          acc;
        logic [31:0] ri;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs1_value = '0; rs2_value = '0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_data", {lhs ^ rhs, 32'd0} == 64'd0 ? 32'd0 : 32'd1, 32'd0);
        check("rst_fields", {20'd0, illegal, operation, metadata, rd == 5'd0}, 32'd1);
        rst = 1'b0;

        // ADD x3,x1,x2
        cycle(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1, acc);
        check("add_lhs", lhs, 32'd5);
        check("add_rhs", rhs, 32'd7);
        check("add_rd", {27'd0, rd}, 32'd3);
        // ADDI x1,x0,-1
        cycle(1'b1, 32'hFFF00093, 32'd0, 32'd9, 1'b1, acc);
        check("addi_rhs", rhs, 32'hFFFFFFFF);
        check("addi_meta", {25'd0, metadata}, 32'h0);
        // SRAI x2,x1,3
        cycle(1'b1, 32'h4030D113, 32'd11, 32'd0, 1'b1, acc);
        check("srai_rhs", rhs, 32'd3);
        check("srai_meta", {25'd0, metadata}, 32'h20);
        check("srai_op", {29'd0, operation}, 32'd5);
        // SLL x4,x1,x2 with rs2=0x25
        cycle(1'b1, 32'h00209233, 32'd1, 32'h25, 1'b1, acc);
        check("sll_rhs", rhs, 32'd5);
        // MUL, then a load opcode: both illegal
        cycle(1'b1, 32'h02208133, 32'd3, 32'd4, 1'b1, acc);
        check("mul_illegal", {31'd0, illegal}, 32'd1);
        check("mul_lhs", lhs, 32'd0);
        cycle(1'b1, 32'h00002083, 32'd3, 32'd4, 1'b1, acc);
        check("load_illegal", {31'd0, illegal}, 32'd1);
        cycle(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, acc);

        // Backpressure: three back-to-back, held off for three cycles
        cycle(1'b1, 32'h002081B3, 32'd10, 32'd20, 1'b0, acc);
        cycle(1'b1, 32'h40208233, 32'd30, 32'd40, 1'b0, acc);
        cycle(1'b1, 32'h0050C313, 32'd50, 32'd60, 1'b0, acc);
        check("bp_third_blocked", {31'd0, acc}, 32'd0);
        acc = 1'b0;
        for (int k = 0; k < 4 && !acc; k++) cycle(1'b1, 32'h0050C313, 32'd50, 32'd60, 1'b1, acc);
        check("bp_third_taken", {31'd0, acc}, 32'd1);
        cycle(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, acc);
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset while both entries are occupied
        cycle(1'b1, 32'h00108093, 32'd1, 32'd0, 1'b0, acc);
        cycle(1'b1, 32'h00210113, 32'd2, 32'd0, 1'b0, acc);
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready",  {31'd0, in_ready},  32'd1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 32'h002081B3, 32'd8, 32'd9, 1'b0, acc);
        check("post_rst_lhs", lhs, 32'd8);
        cycle(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, acc);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            ri = $urandom;
            case ($urandom_range(0, 3))
                0: ri[6:0] = 7'h33;
                1, 2: ri[6:0] = 7'h13;
                default: ;
            endcase
            case ($urandom_range(0, 3))
                0: ri[31:25] = 7'h00;
                1: ri[31:25] = 7'h20;
                2: ri[31:25] = 7'h01;
                default: ;
            endcase
            cycle($urandom_range(0, 3) != 0, ri, $urandom, $urandom, $urandom_range(0, 9) < 7, acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
